// File: rtl/game_speed_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_speed_pkg
//   Shared types and constants for the game time-base controller.
//   - state_t     : top-level sequencing states (IDLE / RUN / PAUSE)
//   - DEF_*       : default parameter values for a 50 MHz board clock
//   - period_of() : tick period in cycles for a given difficulty level
// -----------------------------------------------------------------------------
package game_speed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned DEF_BASE_DIV        = 50_000_000;
  localparam int unsigned DEF_STEP_DIV        = 3_125_000;
  localparam int unsigned DEF_MAX_LEVEL       = 15;
  localparam int unsigned DEF_TICKS_PER_LEVEL = 32;
  localparam int unsigned DEF_CNT_W           = 26;
  localparam int unsigned DEF_LVL_W           = 4;

  // P(L) = base - L*step. Evaluated at 32 bits, which is at least as wide as
  // CNT_W+LVL_W for any sane configuration; callers narrow the result.
  function automatic int unsigned period_of(input int unsigned base_div,
                                            input int unsigned step_div,
                                            input int unsigned lvl);
    return base_div - lvl * step_div;
  endfunction

endpackage

// File: rtl/game_speed_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_speed_ctrl_if
//   Control/status bundle between the game sequencer (master) and the speed
//   controller (slave).
//   master -> slave : start, pause_toggle, level_up (1-cycle pulses), auto_en
//   slave -> master : tick, level, running, paused, max_reached, led
// -----------------------------------------------------------------------------
interface game_speed_ctrl_if #(
  parameter int unsigned LVL_W = 4
);

  logic             start;
  logic             pause_toggle;
  logic             level_up;
  logic             auto_en;

  logic             tick;
  logic [LVL_W-1:0] level;
  logic             running;
  logic             paused;
  logic             max_reached;
  logic             led;

  modport master (
    output start, pause_toggle, level_up, auto_en,
    input  tick, level, running, paused, max_reached, led
  );

  modport slave (
    input  start, pause_toggle, level_up, auto_en,
    output tick, level, running, paused, max_reached, led
  );

endinterface

// File: rtl/game_speed_ctrl_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Period counter that emits a registered one-cycle tick every
//   (term_val + 1) enabled cycles.
//   CLOCK_50 : clock
//   reset    : synchronous, active-high
//   en       : count this cycle (counter frozen when low)
//   clear    : force counter to 0 and suppress the tick (wins over en)
//   term_val : terminal count, i.e. period-1
//   term     : combinational, high on the cycle the terminal count is taken
//   tick     : registered tick, high the cycle after a terminal count
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] term_val,
  output logic             term,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  // '>=' rather than '==': if the period shrinks while the counter is already
  // past the new terminal value, it fires next cycle instead of wrapping.
  assign term = en && !clear && (count >= term_val);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= term;
      if (term)
        count <= '0;
      else if (en)
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_speed_ctrl.sv
// -----------------------------------------------------------------------------
// game_speed_ctrl
//   Game time base: turns CLOCK_50 into a one-cycle `tick` whose period
//   shrinks with the difficulty level, sequences start/pause/resume, and
//   raises the level automatically every TICKS_PER_LEVEL ticks (auto_en) or
//   on a manual level_up pulse. A status LED toggles on every tick.
//   CLOCK_50 : clock
//   reset    : synchronous, active-high
//   bus      : game_speed_ctrl_if.slave
//              in : start, pause_toggle, level_up, auto_en
//              out: tick, level, running, paused, max_reached, led
// -----------------------------------------------------------------------------
module game_speed_ctrl
  import game_speed_pkg::*;
#(
  parameter int unsigned BASE_DIV        = DEF_BASE_DIV,
  parameter int unsigned STEP_DIV        = DEF_STEP_DIV,
  parameter int unsigned MAX_LEVEL       = DEF_MAX_LEVEL,
  parameter int unsigned TICKS_PER_LEVEL = DEF_TICKS_PER_LEVEL,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned LVL_W           = DEF_LVL_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  game_speed_ctrl_if.slave  bus
);

  localparam int unsigned PW   = CNT_W + LVL_W;
  localparam int unsigned TC_W = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;

  // Configuration sanity checks, evaluated at elaboration.
  if (BASE_DIV <= MAX_LEVEL * STEP_DIV) begin : g_chk_period
    $error("game_speed_ctrl: BASE_DIV must exceed MAX_LEVEL*STEP_DIV");
  end
  if ((longint'(BASE_DIV) - 1) >= (longint'(1) << CNT_W)) begin : g_chk_cnt_w
    $error("game_speed_ctrl: CNT_W too narrow for BASE_DIV-1");
  end
  if (longint'(MAX_LEVEL) >= (longint'(1) << LVL_W)) begin : g_chk_lvl_w
    $error("game_speed_ctrl: LVL_W too narrow for MAX_LEVEL");
  end
  if (TICKS_PER_LEVEL == 0) begin : g_chk_tpl
    $error("game_speed_ctrl: TICKS_PER_LEVEL must be at least 1");
  end

  state_t            state;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_nxt;
  logic [TC_W-1:0]   tick_cnt;
  logic [TC_W-1:0]   tick_cnt_nxt;
  logic              max_reached;
  logic              led;
  logic              tick;

  logic [PW-1:0]     period_wide;
  logic [CNT_W-1:0]  term_val;
  logic              div_en;
  logic              div_clear;
  logic              div_term;
  logic              at_max;
  logic              tc_last;
  logic              bump;

  // Period is always >= 1 thanks to the elaboration check, so period-1 never
  // underflows before being narrowed to the counter width.
  assign period_wide = PW'(period_of(BASE_DIV, STEP_DIV, 32'(level)));
  assign term_val    = CNT_W'(period_wide - PW'(1));

  // Counter is held at 0 in IDLE and restarted by start. It stops counting on
  // the cycle pause is taken, so that edge produces neither a tick nor an
  // advance and the remaining period is preserved across the pause.
  assign div_clear = (state == IDLE) || bus.start;
  assign div_en    = (state == RUN) && !bus.pause_toggle;

  tick_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .en       (div_en),
    .clear    (div_clear),
    .term_val (term_val),
    .term     (div_term),
    .tick     (tick)
  );

  assign at_max  = (level == LVL_W'(MAX_LEVEL));
  assign tc_last = (tick_cnt == TC_W'(TICKS_PER_LEVEL - 1));

  // Level / tick-count next state. Automatic and manual requests merge into a
  // single `bump`, so coincident requests raise the level only once.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_nxt    = level;
    tick_cnt_nxt = tick_cnt;
    bump         = 1'b0;
    if (bus.start) begin
      level_nxt    = '0;
      tick_cnt_nxt = '0;
    end else if (state != IDLE) begin
      if (div_term) begin
        if (tc_last) begin
          tick_cnt_nxt = '0;
          bump         = bus.auto_en;
        end else begin
          tick_cnt_nxt = tick_cnt + TC_W'(1);
        end
      end
      if (bus.level_up) begin
        bump         = 1'b1;
        tick_cnt_nxt = '0;
      end
      if (bump && !at_max)
        level_nxt = level + LVL_W'(1);
    end
  end

  // Sequencer. Priority: reset > start > pause_toggle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      level       <= '0;
      tick_cnt    <= '0;
      max_reached <= 1'b0;
      led         <= 1'b0;
    end else begin
      level       <= level_nxt;
      tick_cnt    <= tick_cnt_nxt;
      max_reached <= (level_nxt == LVL_W'(MAX_LEVEL));
      if (div_term)
        led <= ~led;

      if (bus.start) begin
        state <= RUN;
      end else begin
        unique case (state)
          IDLE:    state <= IDLE;
          RUN:     if (bus.pause_toggle) state <= PAUSE;
          PAUSE:   if (bus.pause_toggle) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tick        = tick;
  assign bus.level       = level;
  assign bus.running     = (state == RUN);
  assign bus.paused      = (state == PAUSE);
  assign bus.max_reached = max_reached;
  assign bus.led         = led;

endmodule

// File: tb/tb_game_speed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_speed_ctrl
//   Directed bench for game_speed_ctrl with small periods:
//   BASE_DIV=10, STEP_DIV=2, MAX_LEVEL=3, TICKS_PER_LEVEL=4 -> P = 10,8,6,4.
//   Each table row applies one cycle of pulses, then wait_n quiet cycles,
//   counting ticks (offset 0 = cycle right after the pulse edge) and checking
//   the status outputs at the end of the row.
// -----------------------------------------------------------------------------
module tb_game_speed_ctrl;

  localparam int unsigned LVL_W = 2;

  logic CLOCK_50 = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_speed_ctrl_if #(.LVL_W(LVL_W)) bus ();

  game_speed_ctrl #(
    .BASE_DIV        (10),
    .STEP_DIV        (2),
    .MAX_LEVEL       (3),
    .TICKS_PER_LEVEL (4),
    .CNT_W           (4),
    .LVL_W           (LVL_W)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic s, pt, lu, ae;
    int   wait_n;
    int   ticks;
    int   first;
    int   lvl;
    logic run, pau, mx, led;
  } vec_t;

  vec_t tbl [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic pt, input logic lu, output logic tk);
    bus.start        = s;
    bus.pause_toggle = pt;
    bus.level_up     = lu;
    @(posedge CLOCK_50);
    #1;
    bus.start        = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.level_up     = 1'b0;
    tk = bus.tick;
  endtask

  task automatic apply(input string tag, input vec_t v);
    int   nt;
    int   first;
    logic tk;
    nt    = 0;
    first = -1;
    bus.auto_en = v.ae;
    for (int k = 0; k <= v.wait_n; k++) begin
      if (k == 0) step(v.s, v.pt, v.lu, tk);
      else        step(1'b0, 1'b0, 1'b0, tk);
      if (tk === 1'b1) begin
        if (first < 0) first = k;
        nt++;
      end
    end
    check({tag, ".ticks"},   nt,              v.ticks);
    check({tag, ".first"},   first,           v.first);
    check({tag, ".level"},   32'(bus.level),  v.lvl);
    check({tag, ".running"}, 32'(bus.running), 32'(v.run));
    check({tag, ".paused"},  32'(bus.paused),  32'(v.pau));
    check({tag, ".max"},     32'(bus.max_reached), 32'(v.mx));
    check({tag, ".led"},     32'(bus.led),     32'(v.led));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".tick"},    32'(bus.tick),        0);
    check({tag, ".level"},   32'(bus.level),       0);
    check({tag, ".running"}, 32'(bus.running),     0);
    check({tag, ".paused"},  32'(bus.paused),      0);
    check({tag, ".max"},     32'(bus.max_reached), 0);
    check({tag, ".led"},     32'(bus.led),         0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic tk;
    //              s   pt  lu  ae  wait ticks first lvl run pau mx  led
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0, 14, 0, -1, 0, 1'b0,1'b0,1'b0,1'b0}; // IDLE ignores pt/lu
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 30, 3, 10, 0, 1'b1,1'b0,1'b0,1'b1}; // ticks at 10,20,30
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b1, 40, 4, 10, 1, 1'b1,1'b0,1'b0,1'b1}; // restart, auto L0->1
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 31, 4,  7, 2, 1'b1,1'b0,1'b0,1'b1}; // P=8, L1->2
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1, 23, 4,  5, 3, 1'b1,1'b0,1'b1,1'b1}; // P=6, L2->3
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1, 31, 8,  3, 3, 1'b1,1'b0,1'b1,1'b1}; // P=4, saturated
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,  6, 0, -1, 0, 1'b1,1'b0,1'b0,1'b1}; // restart, count to 6
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0, 19, 0, -1, 0, 1'b0,1'b1,1'b0,1'b1}; // pause 20 cycles
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,  4, 1,  4, 0, 1'b1,1'b0,1'b0,1'b0}; // resume: tick +4
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,  8, 0, -1, 0, 1'b1,1'b0,1'b0,1'b0}; // count to 9
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,  2, 0, -1, 0, 1'b0,1'b1,1'b0,1'b0}; // pause at terminal
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,  0, 0, -1, 0, 1'b1,1'b0,1'b0,1'b0}; // resume
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,  0, 1,  0, 0, 1'b1,1'b0,1'b0,1'b1}; // deferred tick
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,  7, 0, -1, 0, 1'b1,1'b0,1'b0,1'b1}; // count to 8
    tbl[14] = '{1'b0,1'b0,1'b1,1'b0,  9, 2,  1, 1, 1'b1,1'b0,1'b0,1'b1}; // lu past new terminal
    tbl[15] = '{1'b0,1'b0,1'b0,1'b1,  7, 1,  7, 1, 1'b1,1'b0,1'b0,1'b0}; // tick_cnt -> 3
    tbl[16] = '{1'b0,1'b0,1'b0,1'b1,  6, 0, -1, 1, 1'b1,1'b0,1'b0,1'b0}; // count to 7
    tbl[17] = '{1'b0,1'b0,1'b1,1'b1,  0, 1,  0, 2, 1'b1,1'b0,1'b0,1'b1}; // lu + auto: +1 only
    tbl[18] = '{1'b0,1'b0,1'b0,1'b1,  5, 1,  5, 2, 1'b1,1'b0,1'b0,1'b0}; // P=6 confirms L2
    tbl[19] = '{1'b1,1'b1,1'b0,1'b0, 10, 1, 10, 0, 1'b1,1'b0,1'b0,1'b1}; // start beats pause
    tbl[20] = '{1'b0,1'b1,1'b1,1'b0,  3, 0, -1, 1, 1'b0,1'b1,1'b0,1'b1}; // pause + lu
    tbl[21] = '{1'b0,1'b0,1'b1,1'b0,  2, 0, -1, 2, 1'b0,1'b1,1'b0,1'b1}; // lu while paused
    tbl[22] = '{1'b0,1'b1,1'b0,1'b0,  6, 1,  6, 2, 1'b1,1'b0,1'b0,1'b0}; // resume at P=6
    tbl[23] = '{1'b0,1'b0,1'b1,1'b0,  0, 0, -1, 3, 1'b1,1'b0,1'b1,1'b0}; // lu to max
    tbl[24] = '{1'b0,1'b0,1'b1,1'b0,  0, 0, -1, 3, 1'b1,1'b0,1'b1,1'b0}; // lu saturates

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.pause_toggle = 1'b0;
    bus.level_up     = 1'b0;
    bus.auto_en      = 1'b0;
    step(1'b0, 1'b0, 1'b0, tk);
    step(1'b0, 1'b0, 1'b0, tk);
    check_reset_outputs("por");
    reset = 1'b0;

    for (int i = 0; i < 25; i++)
      apply($sformatf("v%0d", i), tbl[i]);

    // Reset mid-RUN, with a simultaneous start that must lose to reset.
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, tk);
    check_reset_outputs("rst_run");
    reset = 1'b0;
    apply("post_rst_idle",  '{1'b0,1'b0,1'b0,1'b0, 11, 0, -1, 0, 1'b0,1'b0,1'b0,1'b0});
    apply("post_rst_start", '{1'b1,1'b0,1'b0,1'b0, 10, 1, 10, 0, 1'b1,1'b0,1'b0,1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
